// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the add-shift multiplier sequencer.
// The state encoding is visible on the State port, so the values are fixed.
package mult_ctrl_pkg;

    // Default operand width and iteration count
    localparam int N_DEFAULT = 8;

    // Sequencer states, encoded 0-4 in this order on the State output
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/mult_ctrl_seq.sv
// Control sequencer for the N-bit signed add-shift multiplier.
// A Run press clears X:A, then runs N fixed-length add/shift iterations.
// The last iteration subtracts to correct for the multiplier sign bit.
// The result is then held until Run is released.
module mult_ctrl_seq
    import mult_ctrl_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset_Load_Clear,
    input  logic       Run,
    input  logic       M,
    output logic       Clr_XA,
    output logic       Add_En,
    output logic       Sub_En,
    output logic       Shift_En,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] State
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            lastIter;

    assign lastIter = (cnt_q == LAST_ITER);
    assign State    = state_q;

    // State and iteration counter registers, cleared asynchronously by reset
    always_ff @(posedge Clk or negedge Reset_Load_Clear) begin
        if (!Reset_Load_Clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update; the counter stops at the last iteration
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!Run) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (lastIter) begin
                    state_d = HOLD;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ADD;
                end
            end
            HOLD: begin
                if (Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: Moore from state, add/subtract also gated by M
    always_comb begin
        Clr_XA   = 1'b0;
        Add_En   = 1'b0;
        Sub_En   = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state_q)
            CLR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            ADD: begin
                Add_En = M & ~lastIter;
                Sub_En = M & lastIter;
                Busy   = 1'b1;
            end
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            HOLD: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule
